// File: rtl/tt_um_reuel_pandher_serial_add_seq.sv
// tt_um_reuel_pandher_serial_add_seq
// Bit-serial 8-bit adder. Two operands are captured from ui_in. A single
// full-adder cell, made of two half adders and an OR, then steps across them
// LSB-first at one bit per clock. The result is presented on uo_out, with a
// busy/done handshake and the carry-out on uio_out.
// Optional feature macro: SERIAL_SUB_EN. When it is defined, uio_in[3] is
// sampled at launch and selects subtract mode, giving A - B.

module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module tt_um_reuel_pandher_serial_add_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [7:0] a_q, b_q, r_q;
    logic       cy_q, cout_q, start_q;
    logic [2:0] cnt_q;
    logic [1:0] state_q;

    logic load_a, load_b, load_any, start_pe, launch;
    logic bp, cy_init;
    logic s0, c0, sum_bit, c1, carry;

    assign load_a   = uio_in[0];
    assign load_b   = uio_in[1];
    assign load_any = load_a | load_b;
    assign start_pe = uio_in[2] & ~start_q;
    // A launch needs a fresh start edge with no load in the same cycle.
    // Loads take priority over start.
    assign launch   = start_pe & ~load_any & ((state_q == IDLE) || (state_q == DONE));

`ifdef SERIAL_SUB_EN
    logic sub_q;
    // Subtract: A + ~B + 1. Carry-in is 1, and the B bit is inverted.
    assign bp      = sub_q ? ~b_q[0] : b_q[0];
    assign cy_init = uio_in[3];

    // Latch the mode at launch so that it holds for the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sub_q <= 1'b0;
        else if (launch) sub_q <= uio_in[3];
    end
`else
    assign bp      = b_q[0];
    assign cy_init = 1'b0;
`endif

    // Full-adder cell built from two half adders and an OR gate.
    half_adder u_ha0 (.a(a_q[0]), .b(bp),   .s(s0),      .c(c0));
    half_adder u_ha1 (.a(s0),     .b(cy_q), .s(sum_bit), .c(c1));
    assign carry = c0 | c1;

    // Previous value of start, used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= uio_in[2];
    end

    // Sequencer: operand capture, serial datapath and state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            r_q     <= 8'h00;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (load_any) begin
                        if (load_a) a_q <= ui_in;
                        if (load_b) b_q <= ui_in;
                        state_q <= IDLE;
                    end else if (launch) begin
                        // A relaunch from DONE reuses the shifted-out operands.
                        state_q <= RUN;
                        cnt_q   <= 3'd0;
                        cy_q    <= cy_init;
                    end
                end
                RUN: begin
                    a_q   <= {1'b0, a_q[7:1]};
                    b_q   <= {1'b0, b_q[7:1]};
                    r_q   <= {sum_bit, r_q[7:1]};
                    cy_q  <= carry;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= DONE;
                        cout_q  <= carry;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ena and the spare uio inputs have no function.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:3]};

    assign uo_out  = r_q;
    assign uio_out = {1'b0, cout_q, (state_q == DONE), (state_q == RUN), 4'b0000};
    assign uio_oe  = 8'b0111_0000;
endmodule

// File: tb/tb_tt_um_reuel_pandher_serial_add_seq.sv
// Bench for tt_um_reuel_pandher_serial_add_seq. Expected {cout, sum} values
// are pushed to a queue at launch and popped when done rises.
// The subtract tests are built only when SERIAL_SUB_EN is defined.

module tb_tt_um_reuel_pandher_serial_add_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int errors = 0;
    int checks = 0;
    logic [8:0] sb[$];

    tt_um_reuel_pandher_serial_add_seq dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic do_load(input bit la, input bit lb, input logic [7:0] v);
        ui_in = v;
        uio_in[0] = la;
        uio_in[1] = lb;
        @(negedge clk);
        uio_in[1:0] = 2'b00;
    endtask

    task automatic launch(input logic [8:0] exp, input bit sub, input bit hold);
        sb.push_back(exp);
        uio_in[3] = sub;
        uio_in[2] = 1'b1;
        @(negedge clk);
        if (!hold) uio_in[2] = 1'b0;
    endtask

    // Counts busy cycles until done rises. A poke value of zero or more
    // pulses start at that point in the run.
    task automatic wait_result(input string tag, input int poke);
        int nb = 0;
        int guard = 0;
        logic [8:0] exp;
        while (!uio_out[5] && guard < 20) begin
            if (uio_out[4]) nb++;
            if (poke >= 0) uio_in[2] = (nb == poke);
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done"}, uio_out[5], 1'b1);
        if (uio_out[5]) begin
            exp = sb.pop_front();
            chk({tag, "_busy_cycles"}, nb, 8);
            chk({tag, "_sum"}, uo_out, exp[7:0]);
            chk({tag, "_cout"}, uio_out[6], exp[8]);
            chk({tag, "_busy_low"}, uio_out[4], 1'b0);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_uo_out", uo_out, 8'h00);
        chk("rst_uio_out", uio_out, 8'h00);
        chk("rst_uio_oe", uio_oe, 8'h70);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x5A + 0x33 = 0x8D
        do_load(1, 0, 8'h5A);
        do_load(0, 1, 8'h33);
        launch(9'h08D, 0, 0);
        wait_result("add_5a_33", -1);

        // 0xFF + 0x01 wraps to 0x00 with carry out
        do_load(1, 0, 8'hFF);
        do_load(0, 1, 8'h01);
        launch(9'h100, 0, 0);
        wait_result("add_ff_01", -1);

        // Relaunch from DONE uses the shifted-out operands (both zero)
        launch(9'h000, 0, 0);
        wait_result("relaunch_zero", -1);

        // Load both registers at once: 0x21 + 0x21 = 0x42
        do_load(1, 1, 8'h21);
        chk("load_both_done_clear", uio_out[5], 1'b0);
        launch(9'h042, 0, 0);
        wait_result("add_both", -1);

        // Start raised with a load in the same cycle is ignored
        ui_in = 8'h0F;
        uio_in[0] = 1'b1;
        uio_in[2] = 1'b1;
        @(negedge clk);
        uio_in = 8'h00;
        chk("start_with_load_busy", uio_out[4], 1'b0);
        @(negedge clk);

        // A second start pulse during RUN does not restart the run
        do_load(0, 1, 8'h01);
        launch(9'h010, 0, 0);
        wait_result("restart_ignored", 3);
        uio_in[2] = 1'b0;

        // Start held high across DONE gives only one run
        do_load(1, 0, 8'h11);
        do_load(0, 1, 8'h22);
        launch(9'h033, 0, 1);
        wait_result("hold_start", -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("hold_no_rerun_%0d", i), uio_out[5:4], 2'b10);
        end
        do_load(1, 0, 8'h01);
        chk("load_in_done_clears", uio_out[5:4], 2'b00);
        uio_in[2] = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a run
        do_load(1, 0, 8'h12);
        do_load(0, 1, 8'h34);
        uio_in[2] = 1'b1;
        @(negedge clk);
        uio_in[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_run_busy", uio_out[4], 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_uo_out", uo_out, 8'h00);
        chk("async_rst_uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_no_done", uio_out[5:4], 2'b00);
        do_load(1, 0, 8'h02);
        do_load(0, 1, 8'h03);
        launch(9'h005, 0, 0);
        wait_result("post_rst_add", -1);

`ifdef SERIAL_SUB_EN
        // Subtract: 0x10 - 0x01 = 0x0F with no borrow
        do_load(1, 0, 8'h10);
        do_load(0, 1, 8'h01);
        launch(9'h10F, 1, 0);
        uio_in[3] = 1'b0;
        wait_result("sub_10_01", -1);
        // Subtract: 0x01 - 0x02 = 0xFF with borrow
        do_load(1, 0, 8'h01);
        do_load(0, 1, 8'h02);
        launch(9'h0FF, 1, 0);
        uio_in[3] = 1'b0;
        wait_result("sub_01_02", -1);
`endif

        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tt_um_reuel_pandher_serial_add_seq.md
# tt_um_reuel_pandher_serial_add_seq

Bit-serial adder sequencer for the Tiny Tapeout half-adder design family. It captures two 8-bit operands from the pins, then steps a single full-adder cell across them LSB-first, one bit per clock. The cell is built from two half adders plus an OR gate, and a carry flop holds the carry between bits. It presents the 8-bit sum, carry-out and a busy/done handshake, and sits as the standalone top-level user module.

## Interface
- WIDTH, 8, operand and sum width. Fixed by the pin map; 8 is the only legal value.
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low. Clears all state.
- ena  in  1  always 1 when powered. Ignored.
- ui_in  in  8  operand data bus.
- uio_in[0]  in  1  load_a: level strobe, captures ui_in into A.
- uio_in[1]  in  1  load_b: level strobe, captures ui_in into B.
- uio_in[2]  in  1  start: rising edge launches an add.
- uio_in[3]  in  1  sub: subtract mode; only used with SERIAL_SUB_EN.
- uio_in[7:4]  in  4  unused.
- uo_out  out  8  result register R.
- uio_out[4]  out  1  busy.
- uio_out[5]  out  1  done.
- uio_out[6]  out  1  cout: final carry.
- uio_out[3:0], uio_out[7]  out  —  driven 0.
- uio_oe  out  8  constant 8'b0111_0000.

## Operation
- Registers:
  - A, B: 8-bit operand registers.
  - R: 8-bit result shift register.
  - cy: carry flop.
  - cnt: 3-bit bit counter.
  - start_q: previous value of start, used for edge detection.
  - state: IDLE, RUN or DONE.
- Start edge: start_pe = uio_in[2] & ~start_q.
- IDLE:
  - load_a writes ui_in into A; load_b writes ui_in into B (each every cycle it is high).
  - load_a and load_b both high: ui_in is written to both registers.
  - start_pe with no load active that cycle: go to RUN; cnt←0; cy←0 (or 1 in subtract mode).
  - start_pe in the same cycle as any load: the load is performed and start is ignored.
- RUN, each cycle:
  - s = A[0] ^ B'[0] ^ cy, where B' = B or ~B per mode.
  - Carry is computed through two half adders: c = (A[0]&B'[0]) | ((A[0]^B'[0])&cy).
  - A and B shift right by one.
  - R ← {s, R[7:1]}; cy ← c; cnt increments.
  - When cnt==7 the cycle's shift completes: go to DONE, and cout ← c.
  - load and start inputs are ignored throughout RUN.
- DONE:
  - done=1; R and cout are held.
  - start_pe with no load active: go to RUN, reusing the current (shifted-out) A/B contents. Operands must be reloaded to add new values.
  - Any load: capture as in IDLE, go to IDLE, done clears.
- Outputs:
  - busy = (state==RUN).
  - R is valid only while done=1; during RUN it shows partial contents.
- Wrap: the sum is modulo 256 and the carry is reported only on cout.

## Timing
- Reset values: state=IDLE, A=B=R=0, cy=0, cnt=0, start_q=0. Outputs: uo_out=0x00, busy=0, done=0, cout=0.
- Latency: start rising edge sampled at clock edge T.
  - busy=1 from T+1 through T+8.
  - done=1 and sum valid from T+9 (busy=0 then).
  - Total: 9 edges from start sample to result.
- Loads take effect at the sampling edge; the register is readable internally the next cycle.
- Start held high generates only one launch. Start must drop and rise again to relaunch.
- Reset asserted mid-RUN: immediate asynchronous return to reset values. A partial result is never reported as done.

## Configuration
- SERIAL_SUB_EN defined:
  - uio_in[3] is sampled at the start edge and latched for the whole run.
  - If latched 1: B' = ~B, cy initialised to 1, and the result is A−B mod 256.
  - In subtract mode, cout=1 means no borrow.
- SERIAL_SUB_EN undefined: uio_in[3] ignored, B' = B, add only.

## Test plan
- Reset, then load A=0x5A and B=0x33, pulse start → busy for 8 cycles, done at T+9, uo_out=0x8D, cout=0.
- A=0xFF, B=0x01, start → uo_out=0x00, cout=1.
- Pulse start again during RUN (after a 0x0F+0x01 launch) → no restart. Result 0x10 arrives at the original T+9; busy width is exactly 8 cycles.
- Hold start high across DONE → no second run. Load A=0x01 in DONE → done=0, state IDLE.
- Assert rst_n low at RUN cycle 4 → all outputs 0 asynchronously. After release, a fresh A=0x02, B=0x03 run gives 0x05.
- SERIAL_SUB_EN with sub=1, A=0x10, B=0x01 → uo_out=0x0F, cout=1. A=0x01, B=0x02 → uo_out=0xFF, cout=0.
